// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg: shared constants and width helper for the debounce block
package input_debounce_pkg;
  localparam int TICK_DIV_DEF = 100000;
  localparam int STABLE_TICKS_DEF = 8;
  localparam int TICK_DIV_SIM = 4;
  localparam int STABLE_TICKS_SIM = 3;
  function automatic int cw(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: two-flop synchroniser, tick-sampled stability counter and optional rising-edge pulse
module debounce_cell
  import input_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF,
  parameter bit EDGE_PULSE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic level,
  output logic pulse
);
  localparam int CW = cw(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], din};
      pulse <= 1'b0;
      if (tick) begin
        if (sync[1] == level) cnt <= '0;
        else if (cnt != LAST) cnt <= cnt + 1'b1;
        else begin
          level <= sync[1];
          cnt   <= '0;
          pulse <= EDGE_PULSE && sync[1];
        end
      end
    end
  end
endmodule

// File: rtl/input_debounce.sv
// input_debounce: shared sample-tick generator feeding per-bit debounce cells for buttons and switches
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int N_BTN = 5,
  parameter int N_SW = 16,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_SW-1:0]  sw_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_SW-1:0]  sw_level,
  output logic             tick
);
  localparam int TW = cw(TICK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  logic [TW-1:0] tcnt;
  logic [N_SW-1:0] sw_pulse_unused;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  end
  assign tick = tcnt == TMAX;
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(.STABLE_TICKS(STABLE_TICKS), .EDGE_PULSE(1'b1)) u_cell (
      .clk(clk), .rst(rst), .tick(tick), .din(btn_in[i]),
      .level(btn_level[i]), .pulse(btn_pulse[i])
    );
  end
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(.STABLE_TICKS(STABLE_TICKS), .EDGE_PULSE(1'b0)) u_cell (
      .clk(clk), .rst(rst), .tick(tick), .din(sw_in[i]),
      .level(sw_level[i]), .pulse(sw_pulse_unused[i])
    );
  end
endmodule
